// File: rtl/c1_bus_frontend_if.sv
// rtl/c1_bus_frontend_if.sv - C1 address bus and cache-core request/response handshake
interface c1_bus_frontend_if #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4
);
  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] address;
  logic                                       req_valid;
  logic                                       req_ready;
  logic [2:0]                                 req_cmd;
  logic [MEM_ADDR_SIZE-1:0]                   req_addr;
  logic [2*BUS_SIZE-1:0]                      req_wdata;
  logic                                       resp_valid;
  logic [2*BUS_SIZE-1:0]                      resp_rdata;

  // Frontend side: consumes the C1 address, produces the core request.
  modport slave (
    input  address,
    output req_valid,
    input  req_ready,
    output req_cmd,
    output req_addr,
    output req_wdata,
    input  resp_valid,
    input  resp_rdata
  );

  // CPU/core side: drives the C1 address and plays the cache core.
  modport master (
    output address,
    input  req_valid,
    output req_ready,
    input  req_cmd,
    input  req_addr,
    input  req_wdata,
    output resp_valid,
    output resp_rdata
  );
endinterface

// File: rtl/c1_bus_frontend.sv
// rtl/c1_bus_frontend.sv - C1 bus two-cycle request decoder and response sequencer
module c1_bus_frontend #(
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int BUS_SIZE          = 16,
  parameter int CACHE_OFFSET_SIZE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire [BUS_SIZE-1:0] data,
  inout  wire [2:0]          command,
  c1_bus_frontend_if.slave   bus
);

  localparam int HI_SIZE = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;

  localparam logic [2:0] CMD_NOP  = 3'd0;
  localparam logic [2:0] READ8    = 3'd1;
  localparam logic [2:0] READ32   = 3'd3;
  localparam logic [2:0] WRITE8   = 3'd5;
  localparam logic [2:0] WRITE16  = 3'd6;
  localparam logic [2:0] WRITE32  = 3'd7;
  localparam logic [2:0] CMD_RESP = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR2 = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    RESP1 = 3'd4,
    RESP2 = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [2:0]                   cmd_q;
  logic [HI_SIZE-1:0]           addr_hi_q;
  logic [CACHE_OFFSET_SIZE-1:0] offset_q;
  logic [BUS_SIZE-1:0]          lo_q;
  logic [BUS_SIZE-1:0]          hi_q;
  logic [2*BUS_SIZE-1:0]        rdata_q;

  logic                         take_cmd;
  logic                         take_offset;
  logic                         take_rdata;
  logic                         req_valid;
  logic                         cmd_oe;
  logic                         data_oe;
  logic [BUS_SIZE-1:0]          data_out;
  logic                         is_read;
  logic [2*BUS_SIZE-1:0]        wdata;

  assign is_read = (cmd_q != CMD_NOP) && (cmd_q <= READ32);

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, capture strobes and bus drive enables.
  always_comb begin
    state_d     = state_q;
    take_cmd    = 1'b0;
    take_offset = 1'b0;
    take_rdata  = 1'b0;
    req_valid   = 1'b0;
    cmd_oe      = 1'b0;
    data_oe     = 1'b0;
    data_out    = '0;
    case (state_q)
      IDLE: begin
        // z/x resolve to a false comparison and keep us idle
        if (command != CMD_NOP) begin
          take_cmd = 1'b1;
          state_d  = ADDR2;
        end
      end
      ADDR2: begin
        take_offset = 1'b1;
        state_d     = ISSUE;
      end
      ISSUE: begin
        req_valid = 1'b1;
        if (bus.req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.resp_valid) begin
          take_rdata = 1'b1;
          state_d    = RESP1;
        end
      end
      RESP1: begin
        cmd_oe  = 1'b1;
        data_oe = is_read;
        if (cmd_q == READ8) begin
          data_out = {{(BUS_SIZE-8){1'b0}}, rdata_q[7:0]};
        end else begin
          data_out = rdata_q[BUS_SIZE-1:0];
        end
        state_d = (cmd_q == READ32) ? RESP2 : IDLE;
      end
      RESP2: begin
        // only READ32 reaches here, so the upper half is always driven
        cmd_oe   = 1'b1;
        data_oe  = 1'b1;
        data_out = rdata_q[2*BUS_SIZE-1:BUS_SIZE];
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction capture: command/address/low word, then offset/high word, then read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q     <= CMD_NOP;
      addr_hi_q <= '0;
      offset_q  <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      rdata_q   <= '0;
    end else begin
      if (take_cmd) begin
        cmd_q     <= command;
        addr_hi_q <= bus.address;
        lo_q      <= data;
      end
      if (take_offset) begin
        offset_q <= bus.address[CACHE_OFFSET_SIZE-1:0];
        if (cmd_q == WRITE32) begin
          hi_q <= data;
        end
      end
      if (take_rdata) begin
        rdata_q <= bus.resp_rdata;
      end
    end
  end

  // Write data packing by transfer width; reads and INV_LINE carry no data.
  always_comb begin
    wdata = '0;
    case (cmd_q)
      WRITE8:  wdata = {{(2*BUS_SIZE-8){1'b0}}, lo_q[7:0]};
      WRITE16: wdata = {{BUS_SIZE{1'b0}}, lo_q};
      WRITE32: wdata = {hi_q, lo_q};
      default: wdata = '0;
    endcase
  end

  assign bus.req_valid = req_valid;
  assign bus.req_cmd   = cmd_q;
  assign bus.req_addr  = {addr_hi_q, offset_q};
  assign bus.req_wdata = wdata;

  assign command = cmd_oe  ? CMD_RESP : 3'bzzz;
  assign data    = data_oe ? data_out : {BUS_SIZE{1'bz}};

endmodule

// File: tb/tb_c1_bus_frontend.sv
// tb/tb_c1_bus_frontend.sv - scoreboard bench for c1_bus_frontend
module tb_c1_bus_frontend;

  localparam int MAS = 19;
  localparam int BS  = 16;
  localparam int COS = 4;

  localparam logic [2:0] READ8    = 3'd1;
  localparam logic [2:0] READ16   = 3'd2;
  localparam logic [2:0] READ32   = 3'd3;
  localparam logic [2:0] INV_LINE = 3'd4;
  localparam logic [2:0] WRITE8   = 3'd5;
  localparam logic [2:0] WRITE16  = 3'd6;
  localparam logic [2:0] WRITE32  = 3'd7;

  typedef struct {
    logic [2:0]  cmd;
    logic [18:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        drv;
    logic [15:0] val;
  } resp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [15:0] data_drv = '0;
  logic        data_oe  = 1'b0;
  logic [2:0]  cmd_drv  = '0;
  logic        cmd_oe   = 1'b0;
  wire  [15:0] data;
  wire  [2:0]  command;

  assign data    = data_oe ? data_drv : 16'hzzzz;
  assign command = cmd_oe  ? cmd_drv  : 3'bzzz;

  c1_bus_frontend_if #(.MEM_ADDR_SIZE(MAS), .BUS_SIZE(BS), .CACHE_OFFSET_SIZE(COS)) bus ();

  c1_bus_frontend #(.MEM_ADDR_SIZE(MAS), .BUS_SIZE(BS), .CACHE_OFFSET_SIZE(COS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data    (data),
    .command (command),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_mis = 0;
  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];
  req_t  cur_req;
  resp_t cur_resp;
  logic  prev_valid = 1'b0;
  int    valid_len  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic undriven(input logic [15:0] v);
    return $isunknown(v) || (v == 16'h0000);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] c, input logic [31:0] w);
    case (c)
      WRITE8:  return {24'h0, w[7:0]};
      WRITE16: return {16'h0, w[15:0]};
      WRITE32: return w;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: compare each presented request and each response cycle against the scoreboard.
  always @(negedge clk) begin
    if (bus.req_valid === 1'b1) begin
      if (!prev_valid) begin
        valid_len = 0;
        if (exp_req_q.size() == 0) begin
          chk("unexp_req", {31'h0, bus.req_valid}, 32'h0);
        end else begin
          cur_req = exp_req_q.pop_front();
        end
      end
      valid_len++;
      chk("req_cmd", {29'h0, bus.req_cmd}, {29'h0, cur_req.cmd});
      chk("req_addr", {13'h0, bus.req_addr}, {13'h0, cur_req.addr});
      chk("req_wdata", bus.req_wdata, cur_req.wdata);
    end
    prev_valid = (bus.req_valid === 1'b1);
    if (!cmd_oe && command === 3'd7) begin
      if (exp_resp_q.size() == 0) begin
        chk("unexp_resp", {29'h0, command}, 32'h0);
      end else begin
        cur_resp = exp_resp_q.pop_front();
        if (cur_resp.drv) begin
          chk("resp_data", {16'h0, data}, {16'h0, cur_resp.val});
        end else begin
          chk("resp_data_z", {31'h0, undriven(data)}, 32'h1);
        end
      end
    end
  end

  task automatic send_req(input logic [2:0] c, input logic [18:0] a, input logic [31:0] w);
    req_t e;
    e.cmd   = c;
    e.addr  = a;
    e.wdata = exp_wdata(c, w);
    exp_req_q.push_back(e);
    cmd_drv     = c;
    cmd_oe      = 1'b1;
    bus.address = a[18:4];
    data_drv    = w[15:0];
    data_oe     = 1'b1;
    @(posedge clk); #1;
    // stray command during ADDR2 must be ignored; upper address bits are junk
    cmd_drv     = READ8;
    bus.address = {11'($urandom), a[3:0]};
    data_drv    = w[31:16];
    @(posedge clk); #1;
    cmd_oe      = 1'b0;
    data_oe     = 1'b0;
    bus.address = '0;
  endtask

  task automatic run_txn(input logic [2:0] c, input logic [18:0] a, input logic [31:0] w,
                         input logic [31:0] r, input int ready_dly, input int resp_dly);
    resp_t rp;
    send_req(c, a, w);
    rp.drv = (c == READ8) || (c == READ16) || (c == READ32);
    rp.val = (c == READ8) ? {8'h00, r[7:0]} : r[15:0];
    exp_resp_q.push_back(rp);
    if (c == READ32) begin
      rp.val = r[31:16];
      exp_resp_q.push_back(rp);
    end
    repeat (ready_dly) begin
      @(posedge clk); #1;
    end
    bus.req_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    chk("valid_len", valid_len, ready_dly + 1);
    chk("wait_valid", {31'h0, bus.req_valid}, 32'h0);
    repeat (resp_dly) begin
      @(posedge clk); #1;
    end
    bus.resp_valid = 1'b1;
    bus.resp_rdata = r;
    @(posedge clk); #1;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = $urandom;
    chk("resp1_cmd", {29'h0, command}, 32'h7);
    if (c == READ32) begin
      @(posedge clk); #1;
      chk("resp2_cmd", {29'h0, command}, 32'h7);
    end
    @(posedge clk); #1;
    chk("cmd_release", {31'h0, undriven({13'h0, command})}, 32'h1);
    chk("data_release", {31'h0, undriven(data)}, 32'h1);
  endtask

  initial begin
    bus.address    = '0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", {31'h0, bus.req_valid}, 32'h0);
    chk("rst_cmd", {29'h0, bus.req_cmd}, 32'h0);
    chk("rst_addr", {13'h0, bus.req_addr}, 32'h0);
    chk("rst_wdata", bus.req_wdata, 32'h0);
    chk("rst_cmd_z", {31'h0, undriven({13'h0, command})}, 32'h1);
    chk("rst_data_z", {31'h0, undriven(data)}, 32'h1);
    rst_n = 1'b1;

    // stray resp_valid and NOP in IDLE, then command left floating
    bus.resp_valid = 1'b1;
    bus.resp_rdata = 32'h1111_2222;
    cmd_drv = 3'd0;
    cmd_oe  = 1'b1;
    @(posedge clk); #1;
    bus.resp_valid = 1'b0;
    cmd_oe = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_valid", {31'h0, bus.req_valid}, 32'h0);
      chk("idle_cmd_z", {31'h0, undriven({13'h0, command})}, 32'h1);
    end

    run_txn(READ8,    19'h000E0, 32'h9999_7777, 32'h0000_00A5, 0, 0);
    run_txn(WRITE32,  19'h001E0, 32'h5555_5555, 32'hDEAD_BEEF, 0, 0);
    run_txn(READ32,   19'h2A5C3, 32'h0000_0000, 32'hF0F0_0F0F, 3, 1);
    run_txn(INV_LINE, 19'h00110, 32'h1234_5678, 32'hCAFE_F00D, 0, 2);
    run_txn(WRITE8,   19'h7FFFF, 32'h3333_ABCD, 32'hA5A5_5A5A, 1, 0);
    run_txn(WRITE16,  19'h40001, 32'h4444_BEEF, 32'h1357_2468, 0, 0);
    run_txn(READ16,   19'h12345, 32'h0000_0000, 32'h1234_CAFE, 0, 0);
    run_txn(READ8,    19'h00008, 32'h0000_0000, 32'h7766_5544, 2, 1);

    // reset while waiting on the core; the late completion must be dropped
    send_req(READ16, 19'h00440, 32'h0);
    bus.req_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rstw_valid", {31'h0, bus.req_valid}, 32'h0);
    chk("rstw_cmd", {29'h0, bus.req_cmd}, 32'h0);
    chk("rstw_addr", {13'h0, bus.req_addr}, 32'h0);
    bus.resp_valid = 1'b1;
    bus.resp_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.resp_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rstw_cmd_z", {31'h0, undriven({13'h0, command})}, 32'h1);
      chk("rstw_data_z", {31'h0, undriven(data)}, 32'h1);
      chk("rstw_idle", {31'h0, bus.req_valid}, 32'h0);
    end

    run_txn(READ16, 19'h0ABCD, 32'h0000_0000, 32'h0000_1357, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("req_q_empty", exp_req_q.size(), 32'h0);
    chk("resp_q_empty", exp_resp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
